// File: rtl/rim_pkg.sv
// Shared types and constants for the rat-in-maze path checker.
// Holds maze size, endpoint coordinates, FSM states, error codes and the unit-move test.
package rim_pkg;

  localparam int MAZE_N        = 8;
  localparam int COORD_W       = 3;
  localparam int STEP_W        = 4;
  localparam int PATH_LEN_DFLT = 15;

  localparam logic [COORD_W-1:0] START_ROW_DFLT = 3'd0;
  localparam logic [COORD_W-1:0] START_COL_DFLT = 3'd7;
  localparam logic [COORD_W-1:0] END_ROW        = 3'd7;
  localparam logic [COORD_W-1:0] END_COL        = 3'd0;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_START = 3'd1,
    ERR_STEP  = 3'd2,
    ERR_WALL  = 3'd3,
    ERR_LEN   = 3'd4
  } err_e;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } cell_t;

  // Widened to 4 bits so row 7 + 1 never aliases row 0.
  function automatic logic unit_move(cell_t prev, cell_t cur);
    logic [3:0] pr;
    logic [3:0] pc;
    logic [3:0] cr;
    logic [3:0] cc;
    pr = {1'b0, prev.row};
    pc = {1'b0, prev.col};
    cr = {1'b0, cur.row};
    cc = {1'b0, cur.col};
    return ((cr == pr + 4'd1) && (cc == pc)) ||
           ((cr == pr) && (cc + 4'd1 == pc));
  endfunction

endpackage

// File: rtl/rim_path_check_if.sv
// Maze/path input and verdict output bundle; err_code/err_step exist only with RIM_CHK_DIAG_EN.
// master drives maze and path beats, slave is the checker.
interface rim_path_check_if;

  logic                        maze_valid;
  logic [rim_pkg::MAZE_N-1:0]  maze;
  logic                        in_valid;
  logic [rim_pkg::COORD_W-1:0] in_row;
  logic [rim_pkg::COORD_W-1:0] in_col;
  logic                        out_valid;
  logic                        pass;

`ifdef RIM_CHK_DIAG_EN
  logic [2:0]                  err_code;
  logic [rim_pkg::STEP_W-1:0]  err_step;

  modport master (
    output maze_valid, maze, in_valid, in_row, in_col,
    input  out_valid, pass, err_code, err_step
  );

  modport slave (
    input  maze_valid, maze, in_valid, in_row, in_col,
    output out_valid, pass, err_code, err_step
  );
`else
  modport master (
    output maze_valid, maze, in_valid, in_row, in_col,
    input  out_valid, pass
  );

  modport slave (
    input  maze_valid, maze, in_valid, in_row, in_col,
    output out_valid, pass
  );
`endif

endinterface

// File: rtl/rim_step_check.sv
// Combinational per-beat legality test: START on the first beat, else STEP, then WALL.
// Zero latency; no handshake of its own.
module rim_step_check
  import rim_pkg::*;
#(
  parameter logic [COORD_W-1:0] START_ROW = START_ROW_DFLT,
  parameter logic [COORD_W-1:0] START_COL = START_COL_DFLT
) (
  input  cell_t             prev_cell,
  input  cell_t             cur_cell,
  input  logic              first_beat,
  input  logic [MAZE_N-1:0] maze_row,
  output err_e              err
);

  always_comb begin
    err = ERR_NONE;
    if (first_beat) begin
      if ((cur_cell.row != START_ROW) || (cur_cell.col != START_COL)) begin
        err = ERR_START;
      end
    end else if (!unit_move(prev_cell, cur_cell)) begin
      err = ERR_STEP;
    end
    if ((err == ERR_NONE) && !maze_row[cur_cell.col]) begin
      err = ERR_WALL;
    end
  end

endmodule

// File: rtl/rim_path_check.sv
// Captures an 8x8 maze, checks the router's coordinate stream, emits a one-cycle verdict 2 cycles
// after the last beat (or after the stream drops short); no backpressure. RIM_CHK_DIAG_EN adds err_code/err_step.
module rim_path_check
  import rim_pkg::*;
#(
  parameter int PATH_LEN  = PATH_LEN_DFLT,
  parameter int START_ROW = 0,
  parameter int START_COL = 7
) (
  input  logic             clk,
  input  logic             rst,
  rim_path_check_if.slave  bus
);

  localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(PATH_LEN - 1);
  localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(MAZE_N - 1);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  row_cnt_q, row_cnt_d;
  logic [MAZE_N-1:0]   maze_q [MAZE_N];
  logic [MAZE_N-1:0]   maze_d [MAZE_N];
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  cell_t               prev_q, prev_d;
  logic                err_seen_q, err_seen_d;
  logic                out_valid_q, out_valid_d;
  logic                pass_q, pass_d;

  cell_t               cur_cell;
  err_e                beat_err;
  logic                first_beat;
  logic                beat_bad;

`ifdef RIM_CHK_DIAG_EN
  err_e                lat_code_q, lat_code_d;
  logic [STEP_W-1:0]   lat_step_q, lat_step_d;
  err_e                err_code_q, err_code_d;
  logic [STEP_W-1:0]   err_step_q, err_step_d;
`endif

  assign cur_cell   = {bus.in_row, bus.in_col};
  assign first_beat = (state_q == ST_WAIT);
  assign beat_bad   = (beat_err != ERR_NONE);

  rim_step_check #(
    .START_ROW (COORD_W'(START_ROW)),
    .START_COL (COORD_W'(START_COL))
  ) u_step_check (
    .prev_cell  (prev_q),
    .cur_cell   (cur_cell),
    .first_beat (first_beat),
    .maze_row   (maze_q[cur_cell.row]),
    .err        (beat_err)
  );

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    maze_d      = maze_q;
    step_cnt_d  = step_cnt_q;
    prev_d      = prev_q;
    err_seen_d  = err_seen_q;
    out_valid_d = 1'b0;
    pass_d      = pass_q;
`ifdef RIM_CHK_DIAG_EN
    lat_code_d  = lat_code_q;
    lat_step_d  = lat_step_q;
    err_code_d  = err_code_q;
    err_step_d  = err_step_q;
`endif

    case (state_q)
      ST_LOAD: begin
        if (bus.maze_valid) begin
          maze_d[row_cnt_q] = bus.maze;
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            state_d   = ST_WAIT;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end else if (row_cnt_q != '0) begin
          // A gap mid-load abandons the partial maze.
          row_cnt_d = '0;
        end
      end

      ST_WAIT, ST_CHECK: begin
        if (bus.in_valid) begin
          if (!err_seen_q && beat_bad) begin
            err_seen_d = 1'b1;
`ifdef RIM_CHK_DIAG_EN
            lat_code_d = beat_err;
            lat_step_d = step_cnt_q;
`endif
          end
          prev_d     = cur_cell;
          step_cnt_d = step_cnt_q + 1'b1;
          state_d    = (step_cnt_q == LAST_STEP) ? ST_REPORT : ST_CHECK;
        end else if (state_q == ST_CHECK) begin
          // Stream ended early; an earlier error keeps priority over LEN.
          if (!err_seen_q) begin
            err_seen_d = 1'b1;
`ifdef RIM_CHK_DIAG_EN
            lat_code_d = ERR_LEN;
            lat_step_d = step_cnt_q;
`endif
          end
          state_d = ST_REPORT;
        end
      end

      ST_REPORT: begin
        out_valid_d = 1'b1;
        pass_d      = !err_seen_q;
        err_seen_d  = 1'b0;
        step_cnt_d  = '0;
`ifdef RIM_CHK_DIAG_EN
        err_code_d  = lat_code_q;
        err_step_d  = lat_step_q;
        lat_code_d  = ERR_NONE;
        lat_step_d  = '0;
`endif
        state_d     = ST_LOAD;
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      row_cnt_q   <= '0;
      step_cnt_q  <= '0;
      prev_q      <= '0;
      err_seen_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pass_q      <= 1'b0;
`ifdef RIM_CHK_DIAG_EN
      lat_code_q  <= ERR_NONE;
      lat_step_q  <= '0;
      err_code_q  <= ERR_NONE;
      err_step_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      step_cnt_q  <= step_cnt_d;
      prev_q      <= prev_d;
      err_seen_q  <= err_seen_d;
      out_valid_q <= out_valid_d;
      pass_q      <= pass_d;
`ifdef RIM_CHK_DIAG_EN
      lat_code_q  <= lat_code_d;
      lat_step_q  <= lat_step_d;
      err_code_q  <= err_code_d;
      err_step_q  <= err_step_d;
`endif
    end
  end

  // Maze contents are only meaningful after a complete load, so they carry no reset.
  always_ff @(posedge clk) begin
    maze_q <= maze_d;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.pass      = pass_q;
`ifdef RIM_CHK_DIAG_EN
  assign bus.err_code  = err_code_q;
  assign bus.err_step  = err_step_q;
`endif

endmodule

// File: tb/tb_rim_path_check.sv
// Directed bench for rim_path_check: vector table of maze/path/verdict records plus reset and load corner sequences.
module tb_rim_path_check;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_START = 3'd1;
  localparam logic [2:0] E_STEP  = 3'd2;
  localparam logic [2:0] E_WALL  = 3'd3;
  localparam logic [2:0] E_LEN   = 3'd4;

  typedef struct {
    string             name;
    logic [7:0][7:0]   rows;
    logic [14:0][5:0]  cells;
    int                n_beats;
    bit                exp_pass;
    logic [2:0]        exp_code;
    logic [3:0]        exp_step;
    int                exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  rim_path_check_if bus_if ();

  rim_path_check dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0][5:0] legal_path();
    logic [14:0][5:0] p;
    for (int k = 0; k < 8; k++)  p[k] = {3'(k), 3'd7};
    for (int k = 8; k < 15; k++) p[k] = {3'd7, 3'(14 - k)};
    return p;
  endfunction

  task automatic load_maze(input logic [7:0][7:0] rows, input int n_rows, input bit junk);
    for (int r = 0; r < n_rows; r++) begin
      @(negedge clk);
      bus_if.maze_valid = 1'b1;
      bus_if.maze       = rows[r];
      bus_if.in_valid   = junk;
      bus_if.in_row     = 3'd0;
      bus_if.in_col     = 3'd7;
    end
    @(negedge clk);
    bus_if.maze_valid = 1'b0;
    bus_if.in_valid   = 1'b0;
  endtask

  task automatic send_beats(input logic [14:0][5:0] cells, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.in_row   = cells[k][5:3];
      bus_if.in_col   = cells[k][2:0];
    end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cnt;
    bit seen;
    load_maze(v.rows, 8, 1'b0);
    send_beats(v.cells, v.n_beats);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 6) begin
      @(negedge clk);
      cnt++;
      if (bus_if.out_valid) seen = 1'b1;
    end
    chk({v.name, " latency"}, seen ? cnt : 99, v.exp_lat);
    chk({v.name, " pass"}, bus_if.pass, v.exp_pass);
`ifdef RIM_CHK_DIAG_EN
    chk({v.name, " err_code"}, bus_if.err_code, v.exp_code);
    chk({v.name, " err_step"}, bus_if.err_step, v.exp_step);
`endif
    @(negedge clk);
    chk({v.name, " out_valid one cycle"}, bus_if.out_valid, 0);
    chk({v.name, " pass held"}, bus_if.pass, v.exp_pass);
  endtask

  vec_t vecs[8];
  vec_t v_ok;
  logic [7:0][7:0] all_open;
  logic [7:0][7:0] all_closed;

  initial begin
    int hi;
    all_open   = {8{8'hFF}};
    all_closed = {8{8'h00}};

    v_ok = '{name: "legal", rows: all_open, cells: legal_path(), n_beats: 15,
             exp_pass: 1'b1, exp_code: E_NONE, exp_step: 4'd0, exp_lat: 1};

    vecs[0] = v_ok;
    vecs[1] = v_ok; vecs[1].name = "wall_row3";  vecs[1].rows[3] = 8'h7F;
    vecs[1].exp_pass = 1'b0; vecs[1].exp_code = E_WALL; vecs[1].exp_step = 4'd3;
    vecs[2] = v_ok; vecs[2].name = "step_jump";  vecs[2].rows[5] = 8'hEF;
    vecs[2].cells[3] = {3'd2, 3'd5}; vecs[2].cells[4] = {3'd2, 3'd4};
    for (int k = 5; k < 10; k++) vecs[2].cells[k] = {3'(k - 2), 3'd4};
    for (int k = 10; k < 15; k++) vecs[2].cells[k] = {3'd7, 3'(13 - k < 0 ? 0 : 13 - k)};
    vecs[2].exp_pass = 1'b0; vecs[2].exp_code = E_STEP; vecs[2].exp_step = 4'd3;
    vecs[3] = v_ok; vecs[3].name = "bad_start";  vecs[3].cells[0] = {3'd1, 3'd7};
    vecs[3].exp_pass = 1'b0; vecs[3].exp_code = E_START; vecs[3].exp_step = 4'd0;
    vecs[4] = v_ok; vecs[4].name = "short10";    vecs[4].n_beats = 10;
    vecs[4].exp_pass = 1'b0; vecs[4].exp_code = E_LEN; vecs[4].exp_step = 4'd10;
    vecs[4].exp_lat = 2;
    vecs[5] = v_ok; vecs[5].name = "wall_start"; vecs[5].rows[0] = 8'h7F;
    vecs[5].exp_pass = 1'b0; vecs[5].exp_code = E_WALL; vecs[5].exp_step = 4'd0;
    vecs[6] = v_ok; vecs[6].name = "row_wrap";   vecs[6].cells[8] = {3'd0, 3'd7};
    vecs[6].exp_pass = 1'b0; vecs[6].exp_code = E_STEP; vecs[6].exp_step = 4'd8;
    vecs[7] = v_ok; vecs[7].name = "short_after_err"; vecs[7].cells[2] = {3'd3, 3'd7};
    vecs[7].n_beats = 5; vecs[7].exp_lat = 2;
    vecs[7].exp_pass = 1'b0; vecs[7].exp_code = E_STEP; vecs[7].exp_step = 4'd2;

    bus_if.maze_valid = 1'b0;
    bus_if.maze       = 8'h00;
    bus_if.in_valid   = 1'b0;
    bus_if.in_row     = 3'd0;
    bus_if.in_col     = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", bus_if.out_valid, 0);
    chk("reset pass", bus_if.pass, 0);
`ifdef RIM_CHK_DIAG_EN
    chk("reset err_code", bus_if.err_code, E_NONE);
    chk("reset err_step", bus_if.err_step, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset mid-path after a passing verdict: no verdict, pass returns to 0.
    run_vec(v_ok);
    load_maze(all_open, 8, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.in_row   = v_ok.cells[k][5:3];
      bus_if.in_col   = v_ok.cells[k][2:0];
    end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-reset pass cleared", bus_if.pass, 0);
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.out_valid) hi++;
    end
    chk("mid-reset no verdict", hi, 0);
    v_ok.name = "after_reset";
    run_vec(v_ok);

    // Partial closed-maze load with stray path beats, then a full open load.
    load_maze(all_closed, 3, 1'b1);
    v_ok.name = "after_partial";
    run_vec(v_ok);

    // Beats right after a verdict land in LOAD and must be dropped.
    send_beats(vecs[3].cells, 3);
    v_ok.name = "after_stray";
    run_vec(v_ok);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
